mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter XLEN, default rapid_pkg::XLEN (32), datapath width.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_valid  in  1  execute result presented this cycle.
REQ-005 o_ready  out  1  unit can accept; high only in IDLE.
REQ-006 i_control_signal  in  control_mem_s  mem, iop (1=store), fcs_opcode[2:0], rd[4:0].
REQ-007 i_rd_output  in  XLEN  ALU result; effective address when mem=1.
REQ-008 i_rs2  in  XLEN  store data.
REQ-009 o_dmem_req, o_dmem_we  out  1 each  data-memory request, write enable.
REQ-010 o_dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
REQ-011 o_dmem_wdata  out  XLEN; o_dmem_wstrb  out  4  byte lanes.
REQ-012 i_dmem_ack  in  1; i_dmem_rdata  in  XLEN  response, rdata valid with ack.
REQ-013 o_wb_valid  out  1; o_wb_rd  out  5; o_wb_data  out  XLEN  writeback.
REQ-014 o_fault  out  1  one-cycle pulse: misaligned or illegal access.

Function
REQ-015 Accept = i_valid && o_ready; inputs latched at accept edge.
REQ-016 FSM states IDLE, WAIT, DONE (enum in rapid_pkg).
REQ-017 Non-mem accept: stay IDLE; next cycle o_wb_valid=1, o_wb_rd=rd, o_wb_data=i_rd_output (latency 1).
REQ-018 Legal mem accept: IDLE->WAIT; o_dmem_req asserted from next cycle, held with addr/we/wdata/wstrb stable until ack.
REQ-019 WAIT with i_dmem_ack: ->DONE; load data registered; o_dmem_req deasserts next cycle.
REQ-020 DONE: one cycle; load -> o_wb_valid=1 with extracted data; store -> o_wb_valid=0; ->IDLE.
REQ-021 Load fcs_opcode: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half selected by addr[1:0], sign/zero extended to XLEN.
REQ-022 Store fcs_opcode: 000 SB (wstrb=0001<<addr[1:0], byte replicated x4), 001 SH (0011 or 1100, half replicated x2), 010 SW (1111).
REQ-023 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; illegal: load 011/110/111, store >=011.
REQ-024 Misaligned/illegal accept: no dmem request, no writeback, o_fault=1 next cycle, stay IDLE.
REQ-025 Load with rd=0: access performed, o_wb_valid=0.
REQ-026 i_dmem_ack outside WAIT ignored; ack in first WAIT cycle legal (minimum mem latency 1).
REQ-027 o_wb_valid, o_fault single-cycle pulses per instruction; never both.

Reset
REQ-028 i_rst asserted: state=IDLE immediately; o_dmem_req=0, o_dmem_we=0, o_wb_valid=0, o_fault=0, all data/addr/strb outputs 0; o_ready=1 after release.
REQ-029 Reset mid-WAIT abandons the transaction; a later stray ack is ignored.

Structure
REQ-030 control_mem_s, XLEN, load/store fcs encodings, mem_state_e live in rapid_pkg.
REQ-031 Sub-module load_align: combinational extraction/extension of rdata by fcs_opcode and addr[1:0].

Verification
REQ-032 ADD result 0x0000_1234 rd=5 -> next cycle wb_valid, rd=5, data 0x0000_1234, no dmem_req.
REQ-033 SB addr 0x103, rs2 0xAABBCCDD -> dmem_addr 0x100, wstrb 1000, wdata 0xDDDDDDDD, no wb.
REQ-034 LB addr 0x102, rdata 0x00800000, ack after 3 cycles -> req held 3 cycles, wb data 0xFFFFFF80; LBU -> 0x00000080.
REQ-035 LW addr 0x102 -> o_fault pulse, no req, no wb, o_ready stays 1.
REQ-036 Reset asserted during WAIT, ack one cycle after release -> req drops asynchronously, ack ignored, no wb.

Source files
------------

// File: rtl/rapid_pkg.sv
// rapid_pkg: shared types and constants for the memory-access stage.
//   XLEN            default datapath width
//   control_mem_s   control bundle handed over from execute
//   mem_state_e     memory-access FSM state encoding
//   FCS_*           load/store width encodings carried in fcs_opcode
//   mem_access_ok() legality + alignment check for a memory instruction
package rapid_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic       mem;         // instruction touches data memory
    logic       iop;         // 1 = store, 0 = load
    logic [2:0] fcs_opcode;  // access width / signedness
    logic [4:0] rd;          // destination register
  } control_mem_s;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  localparam logic [2:0] FCS_LB  = 3'b000;
  localparam logic [2:0] FCS_LH  = 3'b001;
  localparam logic [2:0] FCS_LW  = 3'b010;
  localparam logic [2:0] FCS_LBU = 3'b100;
  localparam logic [2:0] FCS_LHU = 3'b101;
  localparam logic [2:0] FCS_SB  = 3'b000;
  localparam logic [2:0] FCS_SH  = 3'b001;
  localparam logic [2:0] FCS_SW  = 3'b010;

  // True when the encoding exists for the access direction and the
  // address is naturally aligned for the access width.
  function automatic logic mem_access_ok(input logic       iop,
                                         input logic [2:0] fcs,
                                         input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (iop) begin
      case (fcs)
        FCS_SB:  ok = 1'b1;
        FCS_SH:  ok = (addr_lo[0] == 1'b0);
        FCS_SW:  ok = (addr_lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (fcs)
        FCS_LB, FCS_LBU: ok = 1'b1;
        FCS_LH, FCS_LHU: ok = (addr_lo[0] == 1'b0);
        FCS_LW:          ok = (addr_lo == 2'b00);
        default:         ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational extraction of a load result from a memory word.
//   i_rdata      raw word returned by data memory
//   i_fcs_opcode load width / signedness
//   i_addr_lo    byte offset inside the word
//   o_data       selected byte/half/word, sign- or zero-extended to XLEN
module load_align
  import rapid_pkg::*;
#(
  parameter int XLEN = rapid_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_fcs_opcode,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  // Halfwords are only legal at offsets 0 and 2, so addr_lo[1] picks the half.
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_fcs_opcode)
      FCS_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      FCS_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
      FCS_LW:  o_data = i_rdata;
      FCS_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      FCS_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage between execute and writeback.
//   i_clk/i_rst         clock, asynchronous active-high reset
//   i_valid/o_ready     execute hand-off (o_ready high only in IDLE)
//   i_control_signal    mem/iop/fcs_opcode/rd bundle
//   i_rd_output/i_rs2   ALU result (address for memory ops) / store data
//   o_dmem_*/i_dmem_*   single-outstanding data-memory request/response
//   o_wb_*              writeback pulse
//   o_fault             one-cycle pulse on misaligned or illegal access
//   o_dbg_state         current FSM state for observation
//
// Handshake: an instruction is taken on any rising edge where
// i_valid && o_ready; all inputs are captured on that edge. The memory side
// holds o_dmem_req and its address/we/wdata/wstrb steady until the edge on
// which i_dmem_ack is seen (i_dmem_rdata is valid in that same cycle); ack in
// any other state is ignored.
module mem_access_unit
  import rapid_pkg::*;
#(
  parameter int XLEN = rapid_pkg::XLEN
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  control_mem_s       i_control_signal,
  input  logic [XLEN-1:0]    i_rd_output,
  input  logic [XLEN-1:0]    i_rs2,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [XLEN-1:0]    o_dmem_addr,
  output logic [XLEN-1:0]    o_dmem_wdata,
  output logic [3:0]         o_dmem_wstrb,
  input  logic               i_dmem_ack,
  input  logic [XLEN-1:0]    i_dmem_rdata,
  output logic               o_wb_valid,
  output logic [4:0]         o_wb_rd,
  output logic [XLEN-1:0]    o_wb_data,
  output logic               o_fault,
  output mem_state_e         o_dbg_state
);

  mem_state_e      r_state;
  logic            r_iop;
  logic [2:0]      r_fcs;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wstrb;
  logic [XLEN-1:0] r_rdata;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_fault;

  logic            w_accept;
  logic            w_legal;
  logic [XLEN-1:0] w_st_wdata;
  logic [3:0]      w_st_wstrb;
  logic [XLEN-1:0] w_load_data;
  logic            w_done_wb;

  assign w_accept = i_valid && o_ready;
  assign w_legal  = mem_access_ok(i_control_signal.iop,
                                  i_control_signal.fcs_opcode,
                                  i_rd_output[1:0]);

  // Store lane image: data replicated so every enabled lane carries it.
  always_comb begin
    w_st_wdata = '0;
    w_st_wstrb = 4'b0000;
    if (i_control_signal.iop) begin
      case (i_control_signal.fcs_opcode)
        FCS_SB: begin
          w_st_wdata = {(XLEN/8){i_rs2[7:0]}};
          w_st_wstrb = 4'b0001 << i_rd_output[1:0];
        end
        FCS_SH: begin
          w_st_wdata = {(XLEN/16){i_rs2[15:0]}};
          w_st_wstrb = i_rd_output[1] ? 4'b1100 : 4'b0011;
        end
        FCS_SW: begin
          w_st_wdata = i_rs2;
          w_st_wstrb = 4'b1111;
        end
        default: begin
          w_st_wdata = '0;
          w_st_wstrb = 4'b0000;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= MEM_IDLE;
      r_iop      <= 1'b0;
      r_fcs      <= 3'b000;
      r_rd       <= 5'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= 4'b0000;
      r_rdata    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        MEM_IDLE: begin
          if (w_accept) begin
            if (!i_control_signal.mem) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= i_control_signal.rd;
              r_wb_data  <= i_rd_output;
            end else if (!w_legal) begin
              r_fault <= 1'b1;
            end else begin
              r_state <= MEM_WAIT;
              r_iop   <= i_control_signal.iop;
              r_fcs   <= i_control_signal.fcs_opcode;
              r_rd    <= i_control_signal.rd;
              r_addr  <= i_rd_output;
              r_wdata <= w_st_wdata;
              r_wstrb <= w_st_wstrb;
            end
          end
        end
        MEM_WAIT: begin
          if (i_dmem_ack) begin
            r_rdata <= i_dmem_rdata;
            r_state <= MEM_DONE;
          end
        end
        MEM_DONE: r_state <= MEM_IDLE;
        default:  r_state <= MEM_IDLE;
      endcase
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_rdata      (r_rdata),
    .i_fcs_opcode (r_fcs),
    .i_addr_lo    (r_addr[1:0]),
    .o_data       (w_load_data)
  );

  // Loads write back during DONE; rd=0 still performs the access but is
  // not written back. Non-memory results come from the registered pulse,
  // which can only occur in IDLE, so the two sources never overlap.
  assign w_done_wb = (r_state == MEM_DONE) && !r_iop && (r_rd != 5'd0);

  assign o_ready      = (r_state == MEM_IDLE);
  assign o_dmem_req   = (r_state == MEM_WAIT);
  assign o_dmem_we    = (r_state == MEM_WAIT) && r_iop;
  assign o_dmem_addr  = {r_addr[XLEN-1:2], 2'b00};
  assign o_dmem_wdata = r_wdata;
  assign o_dmem_wstrb = r_wstrb;
  assign o_wb_valid   = r_wb_valid || w_done_wb;
  assign o_wb_rd      = (r_state == MEM_DONE) ? r_rd : r_wb_rd;
  assign o_wb_data    = (r_state == MEM_DONE) ? w_load_data : r_wb_data;
  assign o_fault      = r_fault;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import rapid_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst;
  logic         valid;
  logic         ready;
  control_mem_s ctrl;
  logic [31:0]  rd_output;
  logic [31:0]  rs2;
  logic         dmem_req;
  logic         dmem_we;
  logic [31:0]  dmem_addr;
  logic [31:0]  dmem_wdata;
  logic [3:0]   dmem_wstrb;
  logic         dmem_ack;
  logic [31:0]  dmem_rdata;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         fault;
  mem_state_e   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_valid          (valid),
    .o_ready          (ready),
    .i_control_signal (ctrl),
    .i_rd_output      (rd_output),
    .i_rs2            (rs2),
    .o_dmem_req       (dmem_req),
    .o_dmem_we        (dmem_we),
    .o_dmem_addr      (dmem_addr),
    .o_dmem_wdata     (dmem_wdata),
    .o_dmem_wstrb     (dmem_wstrb),
    .i_dmem_ack       (dmem_ack),
    .i_dmem_rdata     (dmem_rdata),
    .o_wb_valid       (wb_valid),
    .o_wb_rd          (wb_rd),
    .o_wb_data        (wb_data),
    .o_fault          (fault),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_legal(input bit iop, input int fcs, input logic [31:0] addr);
    int nbytes;
    if (iop) begin
      case (fcs)
        0: nbytes = 1;
        1: nbytes = 2;
        2: nbytes = 4;
        default: nbytes = 0;
      endcase
    end else begin
      case (fcs)
        0, 4: nbytes = 1;
        1, 5: nbytes = 2;
        2:    nbytes = 4;
        default: nbytes = 0;
      endcase
    end
    if (nbytes == 0) return 1'b0;
    return (addr % nbytes) == 0;
  endfunction

  function automatic logic [31:0] model_load(input int fcs, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = rdata >> ((addr % 4) * 8);
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (fcs)
      0: return (b >= 128) ? b - 32'd256 : b;
      1: return (h >= 32768) ? h - 32'd65536 : h;
      2: return rdata;
      4: return b;
      5: return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input int fcs, input logic [31:0] addr);
    case (fcs)
      0: return 4'(1 << (addr % 4));
      1: return ((addr % 4) == 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input int fcs, input logic [31:0] data);
    case (fcs)
      0: return (data & 32'hFF) * 32'h01010101;
      1: return (data & 32'hFFFF) * 32'h00010001;
      default: return data;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at #1 after a rising edge with the unit idle. lat = cycles the
  // request stays up before the ack edge (>= 1).
  task automatic do_op(input string tag, input bit mem, input bit iop, input int fcs,
                       input int rd, input logic [31:0] res, input logic [31:0] data,
                       input int lat, input logic [31:0] rdata);
    bit legal;
    bit exp_wb;
    chk({tag, ".ready_in"}, 32'(ready), 32'd1);
    ctrl.mem        = mem;
    ctrl.iop        = iop;
    ctrl.fcs_opcode = 3'(fcs);
    ctrl.rd         = 5'(rd);
    rd_output       = res;
    rs2             = data;
    valid           = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    ctrl  = '0;
    rd_output = $urandom;
    rs2       = $urandom;
    if (!mem) begin
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
      chk({tag, ".wb_data"}, wb_data, res);
      chk({tag, ".req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".fault"}, 32'(fault), 32'd0);
      return;
    end
    legal = model_legal(iop, fcs, res);
    if (!legal) begin
      chk({tag, ".fault"}, 32'(fault), 32'd1);
      chk({tag, ".req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
      chk({tag, ".ready"}, 32'(ready), 32'd1);
      @(posedge clk); #1;
      chk({tag, ".fault_end"}, 32'(fault), 32'd0);
      return;
    end
    for (int k = 0; k < lat; k++) begin
      chk({tag, ".req"}, 32'(dmem_req), 32'd1);
      chk({tag, ".ready_busy"}, 32'(ready), 32'd0);
      chk({tag, ".addr"}, dmem_addr, res & 32'hFFFF_FFFC);
      chk({tag, ".we"}, 32'(dmem_we), 32'(iop));
      chk({tag, ".wb_quiet"}, 32'(wb_valid), 32'd0);
      if (iop) begin
        chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(model_strb(fcs, res)));
        chk({tag, ".wdata"}, dmem_wdata, model_wdata(fcs, data));
      end
      if (k == lat - 1) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      @(posedge clk); #1;
    end
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    exp_wb = !iop && (rd != 0);
    chk({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
    chk({tag, ".we_drop"}, 32'(dmem_we), 32'd0);
    chk({tag, ".done_wb"}, 32'(wb_valid), 32'(exp_wb));
    chk({tag, ".done_fault"}, 32'(fault), 32'd0);
    if (exp_wb) begin
      chk({tag, ".done_rd"}, 32'(wb_rd), 32'(rd));
      chk({tag, ".done_data"}, wb_data, model_load(fcs, res, rdata));
    end
    @(posedge clk); #1;
    chk({tag, ".ready_out"}, 32'(ready), 32'd1);
    chk({tag, ".wb_end"}, 32'(wb_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    valid      = 1'b0;
    ctrl       = '0;
    rd_output  = '0;
    rs2        = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.wstrb", 32'(dmem_wstrb), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.wb_rd", 32'(wb_rd), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'(MEM_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.ready", 32'(ready), 32'd1);

    // Directed cases
    do_op("add",   1'b0, 1'b0, 0, 5, 32'h0000_1234, 32'h0, 1, 32'h0);
    do_op("sb",    1'b1, 1'b1, 0, 0, 32'h0000_0103, 32'hAABB_CCDD, 2, 32'h0);
    chk("sb.const_strb", 32'(model_strb(0, 32'h103)), 32'h8);
    do_op("lb",    1'b1, 1'b0, 0, 7, 32'h0000_0102, 32'h0, 3, 32'h0080_0000);
    do_op("lbu",   1'b1, 1'b0, 4, 7, 32'h0000_0102, 32'h0, 3, 32'h0080_0000);
    do_op("lw_mis", 1'b1, 1'b0, 2, 9, 32'h0000_0102, 32'h0, 1, 32'h0);
    do_op("lb_rd0", 1'b1, 1'b0, 0, 0, 32'h0000_0101, 32'h0, 1, 32'h0000_8000);
    do_op("sh_hi", 1'b1, 1'b1, 1, 0, 32'h0000_0202, 32'h1234_5678, 1, 32'h0);
    do_op("lh_hi", 1'b1, 1'b0, 1, 3, 32'h0000_0202, 32'h0, 1, 32'h8001_0000);
    do_op("lhu",   1'b1, 1'b0, 5, 3, 32'h0000_0202, 32'h0, 2, 32'h8001_0000);
    do_op("ld_ill", 1'b1, 1'b0, 3, 3, 32'h0000_0200, 32'h0, 1, 32'h0);
    do_op("st_ill", 1'b1, 1'b1, 4, 0, 32'h0000_0200, 32'h0, 1, 32'h0);

    // Reset during WAIT, stray ack after release
    ctrl.mem = 1'b1; ctrl.iop = 1'b0; ctrl.fcs_opcode = 3'b010; ctrl.rd = 5'd3;
    rd_output = 32'h0000_0200;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    ctrl  = '0;
    chk("rstw.req_up", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstw.req_async", 32'(dmem_req), 32'd0);
    chk("rstw.addr", dmem_addr, 32'd0);
    chk("rstw.state", 32'(dbg_state), 32'(MEM_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("rstw.wb", 32'(wb_valid), 32'd0);
    chk("rstw.req", 32'(dmem_req), 32'd0);
    chk("rstw.ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    chk("rstw.wb2", 32'(wb_valid), 32'd0);
    chk("rstw.state2", 32'(dbg_state), 32'(MEM_IDLE));

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      bit          r_mem;
      bit          r_iop;
      int          r_fcs;
      logic [31:0] r_addr;
      r_mem  = ($urandom_range(0, 3) != 0);
      r_iop  = $urandom_range(0, 1);
      r_fcs  = $urandom_range(0, 7);
      r_addr = r_mem ? (32'h0000_1000 + 32'($urandom_range(0, 255))) : $urandom;
      do_op("rnd", r_mem, r_iop, r_fcs, $urandom_range(0, 31), r_addr, $urandom,
            $urandom_range(1, 4), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        dmem_ack   = 1'b1;
        dmem_rdata = $urandom;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("stray.wb", 32'(wb_valid), 32'd0);
        chk("stray.req", 32'(dmem_req), 32'd0);
        chk("stray.ready", 32'(ready), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
